// File: rtl/result_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : result_accumulator
// Description : Sums BATCH upstream results per batch, counts addition-mode
//               results and presents the total with a valid/ready handshake.
//               Optional macro ACC_SATURATE_EN makes the total saturate.
// Revision    : 1.0 - initial release
// ============================================================================
module result_accumulator #(
  parameter int ACC_W = 8,
  parameter int BATCH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_result,
  input  logic             in_op,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [3:0]       out_add_cnt,
  output logic             out_sat
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt, w_sum;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic [3:0]       r_add_cnt, w_add_nxt;
  logic             r_sat, w_sat_nxt;
  logic             w_accept, w_ovf;

`ifdef ACC_SATURATE_EN
  logic [ACC_W:0] w_sum_ext;
  assign w_sum_ext = {1'b0, r_acc} + {{(ACC_W-5){1'b0}}, in_result};
  assign w_ovf     = w_sum_ext[ACC_W];
  assign w_sum     = w_ovf ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];
`else
  assign w_sum = r_acc + {{(ACC_W-6){1'b0}}, in_result};
  assign w_ovf = 1'b0;
`endif

  assign in_ready = (r_state != DONE) && !clear;
  assign w_accept = in_valid && in_ready;

  // clear wins over both the output handshake and any accept
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_add_nxt   = r_add_cnt;
    w_sat_nxt   = r_sat;
    if (clear || (r_state == DONE && out_ready)) begin
      w_state_nxt = IDLE;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
      w_add_nxt   = '0;
      w_sat_nxt   = 1'b0;
    end else if (w_accept) begin
      w_acc_nxt   = w_sum;
      w_cnt_nxt   = r_cnt + 4'd1;
      w_add_nxt   = r_add_cnt + {3'b000, in_op};
      w_sat_nxt   = r_sat | w_ovf;
      w_state_nxt = (r_cnt == 4'(BATCH-1)) ? DONE : ACCUM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_add_cnt <= '0;
      r_sat     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_acc     <= w_acc_nxt;
      r_cnt     <= w_cnt_nxt;
      r_add_cnt <= w_add_nxt;
      r_sat     <= w_sat_nxt;
    end
  end

  assign out_valid   = (r_state == DONE);
  assign out_acc     = out_valid ? r_acc : '0;
  assign out_add_cnt = out_valid ? r_add_cnt : 4'd0;
  assign out_sat     = r_sat;

endmodule
`default_nettype wire

// File: doc/result_accumulator.md
RESULT_ACCUMULATOR -- requirements
Module: result_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 8: accumulator and out_acc width in bits, legal range 7..16.
REQ-002 SHALL have parameter BATCH, default 8: results per batch, legal range 2..15.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream arithmetic result is present.
REQ-006 SHALL have port in_ready  output  1  block can accept a result this cycle.
REQ-007 SHALL have port in_result  input  6  unsigned result from the add/multiply stage.
REQ-008 SHALL have port in_op  input  1  mode of in_result: 1 = addition, 0 = multiplication.
REQ-009 SHALL have port clear  input  1  synchronous abort of the current batch.
REQ-010 SHALL have port out_valid  output  1  completed batch total is presented.
REQ-011 SHALL have port out_ready  input  1  downstream consumes the batch total.
REQ-012 SHALL have port out_acc  output  ACC_W  batch total.
REQ-013 SHALL have port out_add_cnt  output  4  count of addition-mode results in the batch.
REQ-014 SHALL have port out_sat  output  1  the batch total saturated.

Function
REQ-015 SHALL implement states IDLE (no result accepted in the batch), ACCUM (1..BATCH-1 accepted) and DONE (total presented).
REQ-016 SHALL drive in_ready = 1 in IDLE and ACCUM and 0 in DONE; in_ready SHALL also be 0 in any cycle with clear = 1.
REQ-017 SHALL accept a result only when in_valid and in_ready are both 1; accepting SHALL add zero-extended in_result to the accumulator, increment the batch count and, if in_op = 1, increment the add counter.
REQ-018 SHALL transition IDLE->ACCUM on the first accept and ACCUM->DONE on the BATCH-th accept; out_valid SHALL rise on the clock edge that registers the BATCH-th accept, so it is high in the following cycle.
REQ-019 SHALL hold out_acc, out_add_cnt and out_sat stable while out_valid = 1 and out_ready = 0.
REQ-020 SHALL, on out_valid && out_ready, zero the accumulator, batch count, add counter and out_sat, deassert out_valid and enter IDLE; the next result SHALL be accepted no earlier than the following cycle.
REQ-021 SHALL, when clear = 1, enter IDLE and zero all state on that edge; this takes priority over accept and output handshake, and a result offered that cycle SHALL be dropped.
REQ-022 SHALL present out_acc and out_add_cnt as 0 whenever out_valid = 0.

Reset
REQ-023 SHALL, while rst_n = 0, force state IDLE, accumulator 0, counters 0, out_valid 0, out_acc 0, out_add_cnt 0 and out_sat 0, independent of clk.
REQ-024 SHALL discard a partially accumulated batch when reset occurs mid-batch; in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-025 SHALL honour macro ACC_SATURATE_EN. When it is defined, an accept whose sum exceeds 2^ACC_W-1 SHALL load 2^ACC_W-1 and set out_sat, which stays set for the rest of the batch. When it is undefined, the sum SHALL wrap modulo 2^ACC_W and out_sat SHALL be constant 0.

Verification
REQ-026 SHALL cover this scenario: assert rst_n = 0 after 3 accepts -> outputs all 0; in_ready = 1 one cycle after release; a new batch starts from 0.
REQ-027 SHALL cover this scenario: defaults, 8 results of 10 with in_op alternating starting at 1, out_ready = 1 -> out_valid high for exactly 1 cycle after the 8th accept, with out_acc = 80 and out_add_cnt = 4.
REQ-028 SHALL cover this scenario: defaults, 8 results of 63 -> with ACC_SATURATE_EN, out_acc = 255 and out_sat = 1; without it, out_acc = 248 and out_sat = 0.
REQ-029 SHALL cover this scenario: hold out_ready = 0 for 5 cycles in DONE with in_valid = 1 -> in_ready = 0, no accepts, outputs stable; after the handshake the state is IDLE and the following cycle accepts.
REQ-030 SHALL cover this scenario: after 3 accepts of 20, assert clear with in_valid = 1 and in_result = 20 -> the sample is dropped; the next 8 results of 1 give out_acc = 8.
